// File: rtl/cotm32_pkg.sv
// Core-wide architectural constants shared by the cotm32 datapath blocks.
package cotm32_pkg;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
endpackage

// File: rtl/regfile_read_arbiter_pkg.sv
// Defaults and helpers for the register-file read-port arbiter.
package regfile_read_arbiter_pkg;
    localparam int unsigned XLEN             = cotm32_pkg::XLEN;
    localparam int unsigned NUM_REGS         = cotm32_pkg::NUM_REGS;
    localparam int unsigned DEF_N_REQ        = 3;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    // Round-robin successor over the secondary requesters 1..n_req-1.
    function automatic int unsigned next_rr(input int unsigned k, input int unsigned n_req);
        return (k >= n_req - 1) ? 1 : k + 1;
    endfunction
endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Request/response bundle between the requesters, the shared read port and the arbiter.
interface regfile_read_arbiter_if
    import regfile_read_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned AW    = $clog2(NUM_REGS),
    parameter int unsigned DW    = XLEN
);
    logic [N_REQ-1:0]         i_req_valid;
    logic [N_REQ-1:0][AW-1:0] i_req_addr;
    logic [N_REQ-1:0]         o_req_ready;
    logic [AW-1:0]            o_raddr;
    logic [DW-1:0]            i_rdata;
    logic [N_REQ-1:0]         o_rsp_valid;
    logic [DW-1:0]            o_rsp_data;

    modport slave (
        input  i_req_valid, i_req_addr, i_rdata,
        output o_req_ready, o_raddr, o_rsp_valid, o_rsp_data
    );

    modport master (
        output i_req_valid, i_req_addr, i_rdata,
        input  o_req_ready, o_raddr, o_rsp_valid, o_rsp_data
    );
endinterface

// File: rtl/rr_picker.sv
// Combinational one-hot pick of the first set request bit, scanning upward from ptr_i with wrap.
module rr_picker #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);
    localparam int unsigned IW = $clog2(N);

    logic          found;
    logic [IW-1:0] idx;

    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read port: requester 0 has fixed priority, secondaries are
// served round-robin, and a per-secondary aging counter bounds how long requester 0 can starve them.
module regfile_read_arbiter
    import regfile_read_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ        = DEF_N_REQ,
    parameter int unsigned N_REGS       = NUM_REGS,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    regfile_read_arbiter_if.slave  bus
);
    localparam int unsigned AW = $clog2(N_REGS);
    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned PW = $clog2(N_REQ);

    typedef logic [N_REQ-1:0] vec_t;

    logic [WW-1:0] wait_q [N_REQ-1:1];
    logic [WW-1:0] wait_d [N_REQ-1:1];
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    vec_t          rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;

    vec_t          sec_mask, starved_mask, starved_gnt, sec_gnt, grant;
    logic [AW-1:0] raddr;

    always_comb begin
        sec_mask     = bus.i_req_valid;
        sec_mask[0]  = 1'b0;
        starved_mask = '0;
        for (int k = 1; k < N_REQ; k++) begin
            starved_mask[k] = bus.i_req_valid[k] && (wait_q[k] == WW'(STARVE_LIMIT));
        end
    end

    rr_picker #(.N(N_REQ)) u_pick_starved (
        .req_i (starved_mask),
        .ptr_i (rr_ptr_q),
        .gnt_o (starved_gnt)
    );

    rr_picker #(.N(N_REQ)) u_pick_sec (
        .req_i (sec_mask),
        .ptr_i (rr_ptr_q),
        .gnt_o (sec_gnt)
    );

    // Starved secondaries beat requester 0, which beats ordinary secondaries.
    always_comb begin
        if (|starved_gnt) begin
            grant = starved_gnt;
        end else if (bus.i_req_valid[0]) begin
            grant = vec_t'(1);
        end else begin
            grant = sec_gnt;
        end
    end

    always_comb begin
        raddr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            raddr = raddr | (bus.i_req_addr[k] & {AW{grant[k]}});
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int k = 1; k < N_REQ; k++) begin
            if (bus.i_req_valid[k] && !grant[k]) begin
                wait_d[k] = (wait_q[k] == WW'(STARVE_LIMIT)) ? wait_q[k] : wait_q[k] + WW'(1);
            end else begin
                wait_d[k] = '0;
            end
            if (grant[k]) begin
                rr_ptr_d = PW'(next_rr(k, N_REQ));
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr_q    <= PW'(1);
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int k = 1; k < N_REQ; k++) begin
                wait_q[k] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= grant;
            if (|grant) begin
                rsp_data_q <= bus.i_rdata;
            end
            for (int k = 1; k < N_REQ; k++) begin
                wait_q[k] <= wait_d[k];
            end
        end
    end

    assign bus.o_req_ready = grant;
    assign bus.o_raddr     = raddr;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a combinational register-file read-port model.
module tb_regfile_read_arbiter;
    import regfile_read_arbiter_pkg::*;

    localparam int unsigned N_REQ  = 3;
    localparam int unsigned N_REGS = 32;
    localparam int unsigned SL     = 4;
    localparam int unsigned AW     = $clog2(N_REGS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_read_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(XLEN)) bus ();

    regfile_read_arbiter #(
        .N_REQ        (N_REQ),
        .N_REGS       (N_REGS),
        .STARVE_LIMIT (SL)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [XLEN-1:0] regs [N_REGS];
    assign bus.i_rdata = regs[bus.o_raddr];

    int checks = 0;
    int errors = 0;

    function automatic logic [XLEN-1:0] reg_val(input int i);
        return (i == 5) ? 32'hDEAD_BEEF : (32'hA500_0000 | (32'(i) * 32'h0000_0101));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.i_req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [N_REQ-1:0] exp_gnt;
        for (int i = 0; i < N_REGS; i++) regs[i] = reg_val(i);
        bus.i_req_valid = '0;
        bus.i_req_addr  = '0;

        // Reset state
        #1;
        check("rst_rsp_valid", 32'(bus.o_rsp_valid), 0);
        check("rst_rsp_data", bus.o_rsp_data, 0);
        check("rst_ready", 32'(bus.o_req_ready), 0);
        check("rst_raddr", 32'(bus.o_raddr), 0);
        step();
        rst = 1'b0;

        // Single request from requester 1
        bus.i_req_addr[1] = 5'd5;
        bus.i_req_valid   = 3'b010;
        #1;
        check("single_ready", 32'(bus.o_req_ready), 32'b010);
        check("single_raddr", 32'(bus.o_raddr), 5);
        step();
        bus.i_req_valid = '0;
        #1;
        check("single_rsp_valid", 32'(bus.o_rsp_valid), 32'b010);
        check("single_rsp_data", bus.o_rsp_data, 32'hDEAD_BEEF);
        check("single_idle_ready", 32'(bus.o_req_ready), 0);

        // Priority: requester 0 beats requester 2; requester 2 ages from cycle 1
        do_reset();
        bus.i_req_addr[0] = 5'd3;
        bus.i_req_addr[2] = 5'd7;
        bus.i_req_valid   = 3'b101;
        #1;
        check("prio_ready", 32'(bus.o_req_ready), 32'b001);
        check("prio_raddr", 32'(bus.o_raddr), 3);
        step();
        check("prio_rsp_valid", 32'(bus.o_rsp_valid), 32'b001);
        check("prio_rsp_data", bus.o_rsp_data, reg_val(3));
        step();
        step();
        step();
        check("prio_aged_ready", 32'(bus.o_req_ready), 32'b100);
        check("prio_aged_raddr", 32'(bus.o_raddr), 7);

        // Starvation: requester 0 and 1 continuous
        do_reset();
        bus.i_req_addr[0] = 5'd3;
        bus.i_req_addr[1] = 5'd9;
        bus.i_req_valid   = 3'b011;
        for (int c = 1; c <= 6; c++) begin
            #1;
            exp_gnt = (c == 5) ? 3'b010 : 3'b001;
            check($sformatf("starve_c%0d", c), 32'(bus.o_req_ready), 32'(exp_gnt));
            if (c == 6) begin
                check("starve_rsp_valid", 32'(bus.o_rsp_valid), 32'b010);
                check("starve_rsp_data", bus.o_rsp_data, reg_val(9));
            end
            step();
        end

        // Round-robin between requesters 1 and 2
        do_reset();
        bus.i_req_addr[1] = 5'd1;
        bus.i_req_addr[2] = 5'd2;
        bus.i_req_valid   = 3'b110;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_gnt = (c % 2 == 0) ? 3'b010 : 3'b100;
            check($sformatf("rr_ready_c%0d", c), 32'(bus.o_req_ready), 32'(exp_gnt));
            check($sformatf("rr_raddr_c%0d", c), 32'(bus.o_raddr), (c % 2 == 0) ? 1 : 2);
            step();
        end
        check("rr_rsp_valid", 32'(bus.o_rsp_valid), 32'b100);
        check("rr_rsp_data", bus.o_rsp_data, reg_val(2));

        // Both secondaries starve together with rr_ptr at 2
        do_reset();
        bus.i_req_addr[1] = 5'd11;
        bus.i_req_valid   = 3'b010;
        step();
        bus.i_req_addr[0] = 5'd3;
        bus.i_req_addr[2] = 5'd13;
        bus.i_req_valid   = 3'b111;
        for (int c = 1; c <= 7; c++) begin
            #1;
            exp_gnt = (c == 5) ? 3'b100 : (c == 6) ? 3'b010 : 3'b001;
            check($sformatf("both_c%0d", c), 32'(bus.o_req_ready), 32'(exp_gnt));
            step();
        end

        // Reset during the grant cycle drops the pending response
        do_reset();
        bus.i_req_addr[1] = 5'd5;
        bus.i_req_valid   = 3'b010;
        #1;
        rst = 1'b1;
        #1;
        check("rstgnt_ready_in_reset", 32'(bus.o_req_ready), 32'b010);
        step();
        check("rstgnt_rsp_dropped", 32'(bus.o_rsp_valid), 0);
        bus.i_req_valid = '0;
        rst = 1'b0;

        // Reset after a grant clears the response at once and returns rr_ptr to 1
        bus.i_req_valid = 3'b010;
        #1;
        check("midrst_grant", 32'(bus.o_req_ready), 32'b010);
        step();
        bus.i_req_valid = '0;
        #1;
        check("midrst_rsp_before", 32'(bus.o_rsp_valid), 32'b010);
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(bus.o_rsp_valid), 0);
        check("midrst_rsp_data", bus.o_rsp_data, 0);
        step();
        rst = 1'b0;
        bus.i_req_addr[1] = 5'd1;
        bus.i_req_addr[2] = 5'd2;
        bus.i_req_valid   = 3'b110;
        #1;
        check("midrst_ptr_is_1", 32'(bus.o_req_ready), 32'b010);
        step();
        bus.i_req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
